// File: rtl/euclid_pkg.sv
// Shared definitions for the euclid job controller: register map, CMD and
// STATUS bit positions, and the job record carried through the job FIFO.
package euclid_pkg;

    localparam logic [3:0] REG_X1     = 4'd0;
    localparam logic [3:0] REG_X2     = 4'd1;
    localparam logic [3:0] REG_Y1     = 4'd2;
    localparam logic [3:0] REG_Y2     = 4'd3;
    localparam logic [3:0] REG_CMD    = 4'd4;
    localparam logic [3:0] REG_STATUS = 4'd5;
    localparam logic [3:0] REG_RESULT = 4'd6;
    localparam logic [3:0] REG_TOTAL  = 4'd7;

    localparam int CMD_PUSH  = 0;
    localparam int CMD_CLEAR = 1;

    localparam int ST_JOB_CNT_LSB = 0;
    localparam int ST_RES_CNT_LSB = 8;
    localparam int ST_INFL_LSB    = 16;
    localparam int ST_JOB_FULL    = 24;
    localparam int ST_RES_EMPTY   = 25;
    localparam int ST_OVF         = 26;
    localparam int ST_UNF         = 27;
    localparam int ST_BUSY        = 28;

    localparam int JOB_W = 128;

    typedef struct packed {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] y1;
        logic [31:0] y2;
    } job_t;

endpackage

// File: rtl/euclid_sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous flush that
// overrides any push or pop in the same cycle.
module euclid_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is readable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/euclid_job_ctrl.sv
// Avalon-MM job scheduler feeding one shared euclid_dist datapath: staged
// point quads go through a job FIFO, results come back through a result FIFO.
module euclid_job_ctrl
    import euclid_pkg::*;
#(
    parameter int JOB_DEPTH = 8,
    parameter int RES_DEPTH = 8,
    parameter int DIST_LAT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slaveread,
    input  logic        slavewrite,
    input  logic [3:0]  slaveaddress,
    input  logic [31:0] slavewritedata,
    output logic [31:0] slavereaddata,
    output logic        slavereaddatavalid,
    output logic        slavewaitrequest,
    output logic [31:0] dp_x1,
    output logic [31:0] dp_x2,
    output logic [31:0] dp_y1,
    output logic [31:0] dp_y2,
    input  logic [31:0] dp_dist
);

    localparam int JCW = $clog2(JOB_DEPTH) + 1;
    localparam int RCW = $clog2(RES_DEPTH) + 1;

    logic [31:0]         x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [31:0]         dp_x1_q, dp_x1_d, dp_x2_q, dp_x2_d;
    logic [31:0]         dp_y1_q, dp_y1_d, dp_y2_q, dp_y2_d;
    logic [31:0]         total_q, total_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic [DIST_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [7:0]          infl_q, infl_d;

    logic                wr_cmd, wr_status, rd_result, clear, push_req;
    logic                job_push, issue, tail, capture, res_pop;
    logic                job_full, job_empty, res_full, res_empty;
    logic [JCW-1:0]      job_count;
    logic [RCW-1:0]      res_count;
    logic [JOB_W-1:0]    job_rdata;
    logic [31:0]         res_rdata;
    job_t                job_in, job_head;
    logic [31:0]         status_word;

    assign wr_cmd    = slavewrite && (slaveaddress == REG_CMD);
    assign wr_status = slavewrite && (slaveaddress == REG_STATUS);
    assign rd_result = slaveread && (slaveaddress == REG_RESULT);
    assign clear     = wr_cmd && slavewritedata[CMD_CLEAR];
    assign push_req  = wr_cmd && slavewritedata[CMD_PUSH] && !clear;
    assign job_push  = push_req && !job_full;
    assign res_pop   = rd_result && !res_empty;
    assign tail      = vld_sr_q[DIST_LAT-1];
    assign capture   = tail && !clear;

    // Credit: a job only leaves when its result is guaranteed a slot.
    assign issue = !job_empty && !clear &&
                   ((9'(infl_q) + 9'(res_count)) < 9'(RES_DEPTH));

    assign job_in   = '{x1: x1_q, x2: x2_q, y1: y1_q, y2: y2_q};
    assign job_head = job_rdata;

    euclid_sync_fifo #(.WIDTH(JOB_W), .DEPTH(JOB_DEPTH)) u_job_fifo (
        .clk(clk), .reset(reset), .flush(clear),
        .push(job_push), .pop(issue), .wdata(job_in), .rdata(job_rdata),
        .count(job_count), .full(job_full), .empty(job_empty)
    );

    euclid_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .reset(reset), .flush(clear),
        .push(capture), .pop(res_pop), .wdata(dp_dist), .rdata(res_rdata),
        .count(res_count), .full(res_full), .empty(res_empty)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_JOB_CNT_LSB +: 8] = 8'(job_count);
        status_word[ST_RES_CNT_LSB +: 8] = 8'(res_count);
        status_word[ST_INFL_LSB +: 8]    = infl_q;
        status_word[ST_JOB_FULL]         = job_full;
        status_word[ST_RES_EMPTY]        = res_empty;
        status_word[ST_OVF]              = ovf_q;
        status_word[ST_UNF]              = unf_q;
        status_word[ST_BUSY]             = (infl_q != 8'd0) || !job_empty;
    end

    always_comb begin
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        dp_x1_d = dp_x1_q;
        dp_x2_d = dp_x2_q;
        dp_y1_d = dp_y1_q;
        dp_y2_d = dp_y2_q;
        if (slavewrite) begin
            case (slaveaddress)
                REG_X1:  x1_d = slavewritedata;
                REG_X2:  x2_d = slavewritedata;
                REG_Y1:  y1_d = slavewritedata;
                REG_Y2:  y2_d = slavewritedata;
                default: ;
            endcase
        end
        if (issue) begin
            dp_x1_d = job_head.x1;
            dp_x2_d = job_head.x2;
            dp_y1_d = job_head.y1;
            dp_y2_d = job_head.y2;
        end
    end

    // Pipeline tracking, statistics and sticky flags; CLEAR kills everything
    // in flight, including a capture that would land this very cycle.
    always_comb begin
        vld_sr_d = (vld_sr_q << 1) | DIST_LAT'(issue);
        infl_d   = infl_q + 8'(issue) - 8'(tail);
        total_d  = total_q + 32'(capture);
        if (clear) begin
            vld_sr_d = '0;
            infl_d   = '0;
            total_d  = '0;
        end
        ovf_d = (push_req && job_full) ||
                (ovf_q && !(wr_status && slavewritedata[ST_OVF]));
        unf_d = (rd_result && res_empty) ||
                (unf_q && !(wr_status && slavewritedata[ST_UNF]));
    end

    always_comb begin
        rvalid_d = slaveread;
        rdata_d  = '0;
        if (slaveread) begin
            case (slaveaddress)
                REG_X1:     rdata_d = x1_q;
                REG_X2:     rdata_d = x2_q;
                REG_Y1:     rdata_d = y1_q;
                REG_Y2:     rdata_d = y2_q;
                REG_STATUS: rdata_d = status_word;
                REG_RESULT: rdata_d = res_empty ? 32'd0 : res_rdata;
                REG_TOTAL:  rdata_d = total_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x1_q     <= '0;
            x2_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
            dp_x1_q  <= '0;
            dp_x2_q  <= '0;
            dp_y1_q  <= '0;
            dp_y2_q  <= '0;
            total_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            vld_sr_q <= '0;
            infl_q   <= '0;
        end else begin
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            y1_q     <= y1_d;
            y2_q     <= y2_d;
            dp_x1_q  <= dp_x1_d;
            dp_x2_q  <= dp_x2_d;
            dp_y1_q  <= dp_y1_d;
            dp_y2_q  <= dp_y2_d;
            total_q  <= total_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            vld_sr_q <= vld_sr_d;
            infl_q   <= infl_d;
        end
    end

    assign slavereaddata      = rdata_q;
    assign slavereaddatavalid = rvalid_q;
    assign slavewaitrequest   = 1'b0;
    assign dp_x1              = dp_x1_q;
    assign dp_x2              = dp_x2_q;
    assign dp_y1              = dp_y1_q;
    assign dp_y2              = dp_y2_q;

endmodule

// File: tb/tb_euclid_job_ctrl.sv
// Directed bench for euclid_job_ctrl with a behavioural 4-cycle distance
// datapath attached to the dp_* ports.
module tb_euclid_job_ctrl;
    import euclid_pkg::*;

    logic        clk;
    logic        reset;
    logic        slaveread;
    logic        slavewrite;
    logic [3:0]  slaveaddress;
    logic [31:0] slavewritedata;
    logic [31:0] slavereaddata;
    logic        slavereaddatavalid;
    logic        slavewaitrequest;
    logic [31:0] dp_x1, dp_x2, dp_y1, dp_y2;
    logic [31:0] dp_dist;
    logic [31:0] distPipe0, distPipe1, distPipe2;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;

    euclid_job_ctrl #(.JOB_DEPTH(8), .RES_DEPTH(8), .DIST_LAT(4)) dut (
        .clk(clk),
        .reset(reset),
        .slaveread(slaveread),
        .slavewrite(slavewrite),
        .slaveaddress(slaveaddress),
        .slavewritedata(slavewritedata),
        .slavereaddata(slavereaddata),
        .slavereaddatavalid(slavereaddatavalid),
        .slavewaitrequest(slavewaitrequest),
        .dp_x1(dp_x1),
        .dp_x2(dp_x2),
        .dp_y1(dp_y1),
        .dp_y2(dp_y2),
        .dp_dist(dp_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer Euclidean distance, valid DIST_LAT edges after dp_* change
    function automatic logic [31:0] distModel(input logic [31:0] x1, input logic [31:0] x2,
                                              input logic [31:0] y1, input logic [31:0] y2);
        longint dx, dy, v, r;
        dx = longint'(x2) - longint'(x1);
        dy = longint'(y2) - longint'(y1);
        v  = dx * dx + dy * dy;
        r  = 0;
        while ((r + 1) * (r + 1) <= v && r < 100000) r++;
        return 32'(r);
    endfunction

    always @(posedge clk) begin
        distPipe0 <= distModel(dp_x1, dp_x2, dp_y1, dp_y2);
        distPipe1 <= distPipe0;
        distPipe2 <= distPipe1;
    end
    assign dp_dist = distPipe2;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
        slaveaddress   = addr;
        slavewritedata = data;
        slavewrite     = 1'b1;
        @(negedge clk);
        slavewrite     = 1'b0;
        slavewritedata = '0;
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] data);
        slaveaddress = addr;
        slaveread    = 1'b1;
        @(negedge clk);
        slaveread = 1'b0;
        data      = slavereaddata;
        checkOutput("rvalid", 32'(slavereaddatavalid), 32'd1);
    endtask

    task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        busRead(addr, d);
        checkOutput(tag, d, expected);
    endtask

    task automatic applyStimulus(input logic [31:0] x1, input logic [31:0] x2,
                                 input logic [31:0] y1, input logic [31:0] y2);
        busWrite(REG_X1, x1);
        busWrite(REG_X2, x2);
        busWrite(REG_Y1, y1);
        busWrite(REG_Y2, y2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        slaveread      = 1'b0;
        slavewrite     = 1'b0;
        slaveaddress   = '0;
        slavewritedata = '0;
        idle(3);
        checkOutput("rst_rdata", slavereaddata, 32'd0);
        checkOutput("rst_rvalid", 32'(slavereaddatavalid), 32'd0);
        checkOutput("waitrequest", 32'(slavewaitrequest), 32'd0);
        checkOutput("rst_dp_x2", dp_x2, 32'd0);
        reset = 1'b1;
        idle(1);
        readCheck("rst_status", REG_STATUS, 32'h0200_0000);

        // Single job: (0,3,0,4) -> 5
        applyStimulus(0, 3, 0, 4);
        busWrite(REG_CMD, 32'h1);
        idle(1);
        checkOutput("single_dp_x1", dp_x1, 32'd0);
        checkOutput("single_dp_x2", dp_x2, 32'd3);
        checkOutput("single_dp_y1", dp_y1, 32'd0);
        checkOutput("single_dp_y2", dp_y2, 32'd4);
        idle(3);
        readCheck("single_inflight", REG_STATUS, 32'h1201_0000);
        readCheck("single_captured", REG_STATUS, 32'h0000_0100);
        readCheck("single_result", REG_RESULT, 32'd5);
        readCheck("single_total", REG_TOTAL, 32'd1);
        readCheck("single_empty", REG_STATUS, 32'h0200_0000);

        // Backpressure: 12 jobs with dist = x2, no reads
        busWrite(REG_Y2, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            busWrite(REG_X2, 32'(k));
            busWrite(REG_CMD, 32'h1);
        end
        idle(10);
        readCheck("bp_status", REG_STATUS, 32'h1000_0804);
        readCheck("bp_total", REG_TOTAL, 32'd9);
        readCheck("bp_pop1", REG_RESULT, 32'd1);
        readCheck("bp_pop2", REG_RESULT, 32'd2);
        idle(10);
        readCheck("bp_status2", REG_STATUS, 32'h1000_0802);
        readCheck("bp_total2", REG_TOTAL, 32'd11);

        // Fill job FIFO while stalled, then overflow it
        for (int k = 13; k <= 18; k++) begin
            busWrite(REG_X2, 32'(k));
            busWrite(REG_CMD, 32'h1);
        end
        readCheck("full_status", REG_STATUS, 32'h1100_0808);
        busWrite(REG_X2, 32'd19);
        busWrite(REG_CMD, 32'h1);
        readCheck("ovf_status", REG_STATUS, 32'h1500_0808);
        busWrite(REG_STATUS, 32'h0400_0000);
        readCheck("ovf_cleared", REG_STATUS, 32'h1100_0808);

        // Each pop frees one credit, so queued jobs issue on consecutive edges
        for (int i = 0; i < 8; i++) begin
            logic [31:0] d;
            busRead(REG_RESULT, d);
            checkOutput($sformatf("b2b_result%0d", i), d, 32'(3 + i));
            checkOutput($sformatf("b2b_dp_x2_%0d", i), dp_x2, 32'(10 + i));
        end
        idle(10);
        checkOutput("b2b_dp_last", dp_x2, 32'd18);
        for (int i = 0; i < 8; i++) begin
            readCheck($sformatf("order_result%0d", i), REG_RESULT, 32'(11 + i));
        end
        readCheck("b2b_total", REG_TOTAL, 32'd19);
        readCheck("drained", REG_STATUS, 32'h0200_0000);

        // Underflow
        readCheck("unf_result", REG_RESULT, 32'd0);
        readCheck("unf_status", REG_STATUS, 32'h0A00_0000);
        busWrite(REG_STATUS, 32'h0800_0000);
        readCheck("unf_cleared", REG_STATUS, 32'h0200_0000);

        // CLEAR with 3 results queued and 2 jobs in flight
        applyStimulus(0, 3, 0, 4);
        busWrite(REG_CMD, 32'h1);
        busWrite(REG_CMD, 32'h1);
        busWrite(REG_CMD, 32'h1);
        idle(10);
        readCheck("clr_pre_status", REG_STATUS, 32'h0000_0300);
        readCheck("clr_pre_total", REG_TOTAL, 32'd22);
        busWrite(REG_CMD, 32'h1);
        busWrite(REG_CMD, 32'h1);
        readCheck("clr_inflight", REG_STATUS, 32'h1001_0301);
        busWrite(REG_CMD, 32'h3);
        idle(10);
        readCheck("clr_status", REG_STATUS, 32'h0200_0000);
        readCheck("clr_total", REG_TOTAL, 32'd0);
        readCheck("clr_keep_x2", REG_X2, 32'd3);
        readCheck("clr_keep_y2", REG_Y2, 32'd4);
        readCheck("clr_cmd_read", REG_CMD, 32'd0);
        readCheck("unmapped_read", 4'd12, 32'd0);

        // Asynchronous reset in the middle of a burst with a read outstanding
        busWrite(REG_CMD, 32'h1);
        busWrite(REG_CMD, 32'h1);
        busWrite(REG_CMD, 32'h1);
        slaveaddress = REG_X2;
        slaveread    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_rvalid", 32'(slavereaddatavalid), 32'd1);
        checkOutput("pre_rst_rdata", slavereaddata, 32'd3);
        checkOutput("pre_rst_dp_y2", dp_y2, 32'd4);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_rdata", slavereaddata, 32'd0);
        checkOutput("mid_rst_rvalid", 32'(slavereaddatavalid), 32'd0);
        checkOutput("mid_rst_dp_x1", dp_x1, 32'd0);
        checkOutput("mid_rst_dp_x2", dp_x2, 32'd0);
        checkOutput("mid_rst_dp_y1", dp_y1, 32'd0);
        checkOutput("mid_rst_dp_y2", dp_y2, 32'd0);
        slaveread = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        readCheck("post_rst_status", REG_STATUS, 32'h0200_0000);
        readCheck("post_rst_x2", REG_X2, 32'd0);
        readCheck("post_rst_total", REG_TOTAL, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/euclid_job_ctrl.md
# euclid_job_ctrl

Job scheduler that keeps one shared `euclid_dist` datapath busy from an Avalon-MM slave. Software stages point pairs and pushes them into a job FIFO. The controller issues at most one job per cycle to the datapath and tracks in-flight jobs through its fixed latency. Each distance lands in a result FIFO that software pops by register read. It sits between the Avalon interconnect and a single `euclid_dist` instance, replacing direct per-instance register banks.

## Interface
- `JOB_DEPTH`, default 8: job FIFO entries; power of 2, ≤128.
- `RES_DEPTH`, default 8: result FIFO entries; power of 2, ≤128.
- `DIST_LAT`, default 4: cycles from a `dp_*` register update to a valid `dp_dist`; ≥1.
- `clk  in  1`: single clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-low; 0 clears all state.
- `slaveread  in  1`: Avalon read strobe.
- `slavewrite  in  1`: Avalon write strobe.
- `slaveaddress  in  4`: word address.
- `slavewritedata  in  32`: write data.
- `slavereaddata  out  32`: read data, registered; reset 0.
- `slavereaddatavalid  out  1`: read data valid; reset 0.
- `slavewaitrequest  out  1`: constant 0.
- `dp_x1`, `dp_x2`, `dp_y1`, `dp_y2  out  32 each`: datapath operands, registered; reset 0.
- `dp_dist  in  32`: datapath result.

## Operation
- Register map:
  - 0–3: staging X1, X2, Y1, Y2 (RW); reset 0.
  - 4: CMD (write only). bit0 PUSH copies the staged quad into the job FIFO. bit1 CLEAR empties both FIFOs, kills all in-flight jobs and zeroes the TOTAL register. Reads return 0.
  - 5: STATUS (read only), 32 bits:
    - [7:0] job count.
    - [15:8] result count.
    - [23:16] in-flight count.
    - bit24 job_full.
    - bit25 res_empty.
    - bit26 OVF sticky.
    - bit27 UNF sticky.
    - bit28 busy (in-flight ≠ 0 or job count ≠ 0).
    - Writing 1 to bit26 or bit27 clears that flag.
  - 6: RESULT. A read returns the result FIFO head and pops it. If the FIFO is empty, the read returns 0, sets UNF and pops nothing.
  - 7: TOTAL, a 32-bit count of results captured; wraps at 2^32.
  - 8–15: reads return 0; writes are ignored.
- PUSH while the job FIFO is full: the job is dropped, OVF is set, and no other state changes.
- Issue condition: job FIFO not empty AND in-flight + result count < RES_DEPTH.
  - On issue, the job FIFO is popped, `dp_*` load the job, and a 1 enters the DIST_LAT-deep valid shift register.
  - When no job issues, `dp_*` hold their values.
- Capture: when the shift-register tail is 1, `dp_dist` is written into the result FIFO and TOTAL increments. The credit rule guarantees the result FIFO never overflows.
- In-flight count = number of 1s in the shift register; it is tracked as a counter.
- Simultaneous events:
  - PUSH and issue in the same cycle: both proceed. A PUSH to a full FIFO still drops, even if an issue frees a slot that cycle.
  - RESULT pop and capture in the same cycle: both proceed, and the count is unchanged.
  - CLEAR in the same write as PUSH: CLEAR wins and the push is discarded.
  - CLEAR vs. a capture due that cycle: CLEAR wins, and the shift register is zeroed.
  - CLEAR does not modify the staging registers or the sticky flags.
- Reset asserted mid-operation: all FIFOs, counters, flags, the shift register, `dp_*` and the read path return to 0 immediately.

## Timing
- Read latency is 1. A read in cycle N gives `slavereaddatavalid`=1 with data in N+1. When no read is active, valid=0 and data=0.
- Register reads return pre-edge values. STATUS read in the same cycle as a PUSH shows the count before the push.
- Job path (empty pipeline, result FIFO not full):
  - PUSH written at edge N; the job is issued at edge N+1.
  - The result is captured at edge N+1+DIST_LAT.
  - The earliest RESULT read is issued in the cycle after that edge; its data returns one cycle later.
- Sustained throughput is 1 job/cycle while credit allows.

## Structure
- Shared package `euclid_pkg`:
  - Register address constants `REG_X1`..`REG_TOTAL`.
  - STATUS bit positions.
  - The CMD bit positions (PUSH, CLEAR).
  - The job record width (128 bits).
- One sub-module `euclid_sync_fifo` (parameters WIDTH, DEPTH), used twice:
  - Job FIFO: width 128.
  - Result FIFO: width 32.
  - Each provides count, full, empty and a synchronous flush.
- The `euclid_dist` instance lives in the integrating top, not in this block.

## Test plan
- Single job (DIST_LAT=4):
  - Stage X1=0, X2=3, Y1=0, Y2=4, then PUSH.
  - Expect `dp_*`=(0,3,0,4) one edge later and the capture 4 edges after that.
  - RESULT reads 5, TOTAL=1, STATUS res_empty=1.
- Back-to-back jobs: push 8 jobs with distinct quads → jobs issue on consecutive edges; RESULT returns all 8 in order; TOTAL=8.
- Backpressure (RES_DEPTH=8): push 12 jobs, no reads → result count 8, in-flight 0, job count 4. Pop 2 → exactly 2 more jobs issue.
- Overflow:
  - Push 9 jobs while issue is stalled (result FIFO full) → OVF=1, job count 8.
  - Write STATUS bit26=1 → OVF=0.
  - Read RESULT on an empty FIFO → returns 0, UNF=1.
- CLEAR: write CMD=0x3 with 2 jobs in flight and 3 results queued → all counts 0, TOTAL=0, no late capture, staging regs unchanged.
- Reset: drive `reset`=0 mid-burst → all outputs 0 at once. After release, STATUS reads 0x02000000 (res_empty only).
